// File: rtl/ddr3_ctrl_pkg.sv
// Shared definitions between the DDR3 controller and its user-side request queue.
// Holds the controller data-state encodings and the layout of a queued request.
package ddr3_ctrl_pkg;

  localparam int ADDR_WIDTH     = 17;
  localparam int DQ_BITWIDTH    = 16;
  localparam int STATE_BITWIDTH = 5;

  localparam logic [STATE_BITWIDTH-1:0] STATE_WRITE_DATA = 5'd8;
  localparam logic [STATE_BITWIDTH-1:0] STATE_READ_DATA  = 5'd11;

  // One queued user request: {write, {bank, address}, write data}
  typedef struct packed {
    logic                   write;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DQ_BITWIDTH-1:0] wdata;
  } user_req_t;

  localparam int USER_REQ_WIDTH = $bits(user_req_t);

endpackage

// File: rtl/ddr3_req_fifo.sv
// Synchronous request FIFO with first-word-fall-through head.
// The head entry is visible on head_o whenever the FIFO is non-empty.
module ddr3_req_fifo
  import ddr3_ctrl_pkg::*;
#(
  parameter int WIDTH = USER_REQ_WIDTH,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == (AW+1)'(0));
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign level_o   = count_q;

  // Storage write; contents are don't-care until pushed, so no reset here
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_user_request_queue.sv
// User request queue in front of ddr3_memory_controller.
// Presents the oldest request to the controller, pops it exactly once when the
// controller enters the matching data state, and returns read data after a
// fixed latency as a one-cycle response pulse. Only one read is in flight.
module ddr3_user_request_queue #(
  parameter int ADDR_WIDTH     = ddr3_ctrl_pkg::ADDR_WIDTH,
  parameter int DQ_BITWIDTH    = ddr3_ctrl_pkg::DQ_BITWIDTH,
  parameter int FIFO_DEPTH     = 8,
  parameter int STATE_BITWIDTH = ddr3_ctrl_pkg::STATE_BITWIDTH,
  parameter logic [STATE_BITWIDTH-1:0] STATE_WRITE_DATA = ddr3_ctrl_pkg::STATE_WRITE_DATA,
  parameter logic [STATE_BITWIDTH-1:0] STATE_READ_DATA  = ddr3_ctrl_pkg::STATE_READ_DATA,
  parameter int READ_LATENCY   = 32,
  localparam int LW            = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [DQ_BITWIDTH-1:0]    req_wdata,
  output logic                      rsp_valid,
  output logic [DQ_BITWIDTH-1:0]    rsp_rdata,
  output logic [ADDR_WIDTH-1:0]     rsp_address,
  input  logic [STATE_BITWIDTH-1:0] main_state,
  input  logic [DQ_BITWIDTH-1:0]    data_from_ram,
  output logic                      write_enable,
  output logic                      read_enable,
  output logic [ADDR_WIDTH-1:0]     i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]    data_to_ram,
  output logic [LW:0]               fifo_level,
  output logic                      sequence_error
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DQ_BITWIDTH;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [STATE_BITWIDTH-1:0] prev_state_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic                      err_q, err_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DQ_BITWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0]     rsp_addr_q, rsp_addr_d;
  logic [ADDR_WIDTH-1:0]     last_addr_q;
  logic [DQ_BITWIDTH-1:0]    last_data_q;

  logic                      push_s;
  logic                      pop_s;
  logic [REQ_W-1:0]          head_s;
  logic                      head_write_s;
  logic [ADDR_WIDTH-1:0]     head_addr_s;
  logic [DQ_BITWIDTH-1:0]    head_data_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic                      wr_entry_s;
  logic                      rd_entry_s;
  logic                      more_after_pop_s;
  logic                      nonempty_next_s;

  assign req_ready = ~fifo_full_s;
  assign push_s    = req_valid & req_ready;

  ddr3_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({req_write, req_address, req_wdata}),
    .head_o  (head_s),
    .level_o (fifo_level),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign head_write_s = head_s[REQ_W-1];
  assign head_addr_s  = head_s[DQ_BITWIDTH +: ADDR_WIDTH];
  assign head_data_s  = head_s[DQ_BITWIDTH-1:0];

  // A data state counts once, on the first cycle the controller is in it
  assign wr_entry_s = (main_state == STATE_WRITE_DATA) && (prev_state_q != STATE_WRITE_DATA);
  assign rd_entry_s = (main_state == STATE_READ_DATA)  && (prev_state_q != STATE_READ_DATA);

  // Occupancy after this cycle, used to choose between issuing again and idling
  assign more_after_pop_s = (fifo_level > (LW+1)'(1)) || push_s;
  assign nonempty_next_s  = !fifo_empty_s || push_s;

  // Controller-facing outputs: live head while issuing, last head otherwise
  assign write_enable        = (state_q == S_ISSUE) &&  head_write_s;
  assign read_enable         = (state_q == S_ISSUE) && !head_write_s;
  assign i_user_data_address = (state_q == S_ISSUE) ? head_addr_s : last_addr_q;
  assign data_to_ram         = (state_q == S_ISSUE) ? head_data_s : last_data_q;

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_address    = rsp_addr_q;
  assign sequence_error = err_q;

  // Next-state, pop decision, read latency counter and response capture
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (wr_entry_s) begin
          if (head_write_s) begin
            pop_s   = 1'b1;
            state_d = more_after_pop_s ? S_ISSUE : S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end else if (rd_entry_s) begin
          if (!head_write_s) begin
            pop_s     = 1'b1;
            rd_addr_d = head_addr_s;
            cnt_d     = CNT_LOAD;
            state_d   = S_WAIT_RD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_RD: begin
        if (cnt_q == CNT_W'(0)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = data_from_ram;
          rsp_addr_d  = rd_addr_q;
          state_d     = nonempty_next_s ? S_ISSUE : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, sticky error and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prev_state_q <= '0;
      cnt_q        <= '0;
      rd_addr_q    <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= main_state;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_addr_q   <= rsp_addr_d;
    end
  end

  // Remember the last presented head so the controller sees stable values when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q <= '0;
      last_data_q <= '0;
    end else if (state_q == S_ISSUE) begin
      last_addr_q <= head_addr_s;
      last_data_q <= head_data_s;
    end else begin
      last_addr_q <= last_addr_q;
      last_data_q <= last_data_q;
    end
  end

endmodule
